// File: rtl/acc_exec_unit_pkg.sv
// rtl/acc_exec_unit_pkg.sv - shared opcodes, FSM states and flag indices for acc_exec_unit
package acc_exec_unit_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDI  = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SUBI = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_ANDI = 4'h9;
  localparam logic [3:0] OP_OR   = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MEM_RD = 3'd1,
    S_MEM_WR = 3'd2,
    S_EXEC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Opcodes whose second operand comes from data memory.
  function automatic logic is_mem_src(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - combinational accumulator ALU with carry and overflow outputs
module acc_alu
  import acc_exec_unit_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  input  logic [3:0]        shamt,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              v
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]        sum_add;
  logic [DATA_W:0]        sum_sub;
  logic [DATA_W:0]        shl_ext;
  logic signed [DATA_W:0] shr_ext;

  always_comb begin
    sum_add = {1'b0, a} + {1'b0, b};
    sum_sub = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    // One guard bit on each side catches the last bit shifted out; zero shift leaves it 0.
    shl_ext = {1'b0, a} << shamt;
    shr_ext = $signed({a, 1'b0}) >>> shamt;

    result = b;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        result = sum_add[DATA_W-1:0];
        c      = sum_add[DATA_W];
        v      = (a[MSB] == b[MSB]) && (sum_add[MSB] != a[MSB]);
      end
      OP_SUB, OP_SUBI: begin
        result = sum_sub[DATA_W-1:0];
        c      = sum_sub[DATA_W];
        v      = (a[MSB] != b[MSB]) && (sum_sub[MSB] != a[MSB]);
      end
      OP_AND, OP_ANDI: result = a & b;
      OP_OR:           result = a | b;
      OP_XOR:          result = a ^ b;
      OP_SHL: begin
        result = shl_ext[DATA_W-1:0];
        c      = shl_ext[DATA_W];
      end
      OP_SHR: begin
        result = shr_ext[DATA_W:1];
        c      = shr_ext[0];
      end
      default: result = b;
    endcase
  end

endmodule

// File: rtl/acc_exec_unit.sv
// rtl/acc_exec_unit.sv - sequenced accumulator execution unit with req/ack data memory port
module acc_exec_unit
  import acc_exec_unit_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OPND_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [OPND_W-1:0] operand,
  output logic              busy,
  output logic              done,
  output logic [OPND_W-1:0] mem_addr,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] acc,
  output logic [3:0]        flags
);

  function automatic logic [DATA_W-1:0] sext(input logic [OPND_W-1:0] x);
    return DATA_W'($signed(x));
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [OPND_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [3:0]          flags_q, flags_d;

  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                alu_v;

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (acc_q),
    .b      (opnd_q),
    .op     (op_q),
    .shamt  (addr_q[3:0]),
    .result (alu_res),
    .c      (alu_c),
    .v      (alu_v)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = opcode;
          addr_d = operand;
          opnd_d = sext(operand);
          if (is_mem_src(opcode))   state_d = S_MEM_RD;
          else if (opcode == OP_ST) state_d = S_MEM_WR;
          else                      state_d = S_EXEC;
        end
      end
      S_MEM_RD: begin
        if (mem_ack) begin
          opnd_d  = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_MEM_WR: begin
        if (mem_ack) state_d = S_DONE;
      end
      S_EXEC: begin
        state_d = S_DONE;
        // Loads touch only Z/N; every ALU op rewrites all four flags.
        if (op_q == OP_LD || op_q == OP_LDI) begin
          acc_d          = alu_res;
          flags_d[FLG_Z] = (alu_res == '0);
          flags_d[FLG_N] = alu_res[DATA_W-1];
        end else if (op_q >= OP_ADD && op_q <= OP_SHR) begin
          acc_d          = alu_res;
          flags_d[FLG_Z] = (alu_res == '0);
          flags_d[FLG_N] = alu_res[DATA_W-1];
          flags_d[FLG_C] = alu_c;
          flags_d[FLG_V] = alu_v;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      addr_q  <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign mem_rd_req = (state_q == S_MEM_RD);
  assign mem_wr_req = (state_q == S_MEM_WR);
  assign mem_addr   = addr_q;
  assign mem_wdata  = acc_q;
  assign acc        = acc_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_acc_exec_unit.sv
// tb/tb_acc_exec_unit.sv - directed self-checking bench for acc_exec_unit
module tb_acc_exec_unit;

  localparam int DW = 16;
  localparam int OW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    opcode;
  logic [OW-1:0] operand;
  logic          busy;
  logic          done;
  logic [OW-1:0] mem_addr;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic [DW-1:0] acc;
  logic [3:0]    flags;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  acc_exec_unit #(.DATA_W(DW), .OPND_W(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .operand    (operand),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .acc        (acc),
    .flags      (flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one instruction at cycle 0 and plays memory: ack after ack_dly request cycles.
  task automatic exec_op(input logic [3:0] op, input logic [OW-1:0] opnd, input int ack_dly,
                         input logic [DW-1:0] rdata, input bit spam,
                         output int t_done, output int t_ack, output int n_wr,
                         output logic [OW-1:0] seen_addr, output logic [DW-1:0] seen_wdata);
    int req_cnt;
    t_done     = -1;
    t_ack      = -1;
    n_wr       = 0;
    req_cnt    = 0;
    seen_addr  = '0;
    seen_wdata = '0;
    opcode     = op;
    operand    = opnd;
    start      = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      start   = spam && busy;
      if (mem_rd_req || mem_wr_req) begin
        seen_addr = mem_addr;
        if (req_cnt == ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
          t_ack     = t;
          if (mem_wr_req) begin
            n_wr++;
            seen_wdata = mem_wdata;
          end
        end
        req_cnt++;
      end
      if (done) begin
        t_done = t;
        break;
      end
    end
    start   = 1'b0;
    mem_ack = 1'b0;
    if (t_done < 0) check("done_timeout", 32'(t_done), 32'(0));
    @(posedge clk); #1;
  endtask

  int            td, ta, nw;
  logic [OW-1:0] sa;
  logic [DW-1:0] sw;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    opcode    = 4'h0;
    operand   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc",   32'(acc),        32'h0);
    check("rst_flags", 32'(flags),      32'h0);
    check("rst_busy",  32'(busy),       32'h0);
    check("rst_done",  32'(done),       32'h0);
    check("rst_rdreq", 32'(mem_rd_req), 32'h0);
    check("rst_wrreq", 32'(mem_wr_req), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    exec_op(4'h2, 11'h7FF, 0, 16'h0, 1'b0, td, ta, nw, sa, sw);
    check("ldi_lat",   32'(td),    32'd2);
    check("ldi_acc",   32'(acc),   32'hFFFF);
    check("ldi_flags", 32'(flags), 32'b0100);

    exec_op(4'h5, 11'h001, 0, 16'h0, 1'b0, td, ta, nw, sa, sw);
    check("addi_lat",   32'(td),    32'd2);
    check("addi_acc",   32'(acc),   32'h0000);
    check("addi_flags", 32'(flags), 32'b1010);

    exec_op(4'h2, 11'h3FF, 0, 16'h0, 1'b0, td, ta, nw, sa, sw);
    check("ldi2_acc",   32'(acc),   32'h03FF);
    check("ldi2_flags", 32'(flags), 32'b0010);

    exec_op(4'h4, 11'h020, 3, 16'h7C01, 1'b0, td, ta, nw, sa, sw);
    check("add_addr",  32'(sa),     32'h020);
    check("add_ack",   32'(ta),     32'd4);
    check("add_lat",   32'(td),     32'(ta + 2));
    check("add_acc",   32'(acc),    32'h8000);
    check("add_flags", 32'(flags),  32'b0101);

    exec_op(4'h3, 11'h005, 2, 16'h0, 1'b1, td, ta, nw, sa, sw);
    check("st_addr",   32'(sa),     32'h005);
    check("st_wdata",  32'(sw),     32'h8000);
    check("st_writes", 32'(nw),     32'd1);
    check("st_lat",    32'(td),     32'(ta + 1));
    check("st_ack",    32'(ta),     32'd3);
    check("st_flags",  32'(flags),  32'b0101);
    check("st_acc",    32'(acc),    32'h8000);
    check("st_idle",   32'(busy),   32'h0);

    exec_op(4'h1, 11'h011, 0, 16'hC001, 1'b0, td, ta, nw, sa, sw);
    check("ld_lat",   32'(td),    32'd3);
    check("ld_acc",   32'(acc),   32'hC001);
    check("ld_flags", 32'(flags), 32'b0101);

    exec_op(4'hD, 11'h001, 0, 16'h0, 1'b0, td, ta, nw, sa, sw);
    check("shr_acc",   32'(acc),   32'hE000);
    check("shr_flags", 32'(flags), 32'b0110);

    exec_op(4'hC, 11'h004, 0, 16'h0, 1'b0, td, ta, nw, sa, sw);
    check("shl_acc",   32'(acc),   32'h0000);
    check("shl_flags", 32'(flags), 32'b1000);

    exec_op(4'h7, 11'h001, 0, 16'h0, 1'b0, td, ta, nw, sa, sw);
    check("subi_acc",   32'(acc),   32'hFFFF);
    check("subi_flags", 32'(flags), 32'b0100);

    exec_op(4'h6, 11'h040, 1, 16'h7FFF, 1'b0, td, ta, nw, sa, sw);
    check("sub_lat",   32'(td),    32'(ta + 2));
    check("sub_acc",   32'(acc),   32'h8000);
    check("sub_flags", 32'(flags), 32'b0110);

    exec_op(4'hD, 11'h000, 0, 16'h0, 1'b0, td, ta, nw, sa, sw);
    check("shr0_acc",   32'(acc),   32'h8000);
    check("shr0_flags", 32'(flags), 32'b0100);

    exec_op(4'hE, 11'h000, 0, 16'h0, 1'b0, td, ta, nw, sa, sw);
    check("nop_lat",   32'(td),    32'd2);
    check("nop_acc",   32'(acc),   32'h8000);
    check("nop_flags", 32'(flags), 32'b0100);

    exec_op(4'h9, 11'h7F0, 0, 16'h0, 1'b0, td, ta, nw, sa, sw);
    check("andi_acc",   32'(acc),   32'h8000);
    check("andi_flags", 32'(flags), 32'b0100);

    exec_op(4'hB, 11'h033, 0, 16'h8000, 1'b0, td, ta, nw, sa, sw);
    check("xor_acc",   32'(acc),   32'h0000);
    check("xor_flags", 32'(flags), 32'b1000);

    exec_op(4'h2, 11'h123, 0, 16'h0, 1'b0, td, ta, nw, sa, sw);
    opcode  = 4'h1;
    operand = 11'h050;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mrd_req", 32'(mem_rd_req), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mrst_rdreq", 32'(mem_rd_req), 32'h0);
    check("mrst_acc",   32'(acc),        32'h0);
    check("mrst_flags", 32'(flags),      32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_busy", 32'(busy), 32'h0);

    exec_op(4'hA, 11'h010, 0, 16'h00A5, 1'b0, td, ta, nw, sa, sw);
    check("or_acc",   32'(acc),   32'h00A5);
    check("or_flags", 32'(flags), 32'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
